kernel_weight_sram: RTL

Synchronous single-port memory responder serving the kernel/weight memory interface driven by the CNN top: address, active-low chip-select/write-enable/output-enable, 32-bit data in and out. It stores kernel and weight words written during learn and returns them during classify.
- Configurable read-pipeline latency.
- Read-valid strobe.
- Sticky uninitialised-read error flag.
- Saturating access counters for bench and debug visibility.

---
 rtl/kernel_weight_sram.sv | 126 ++++++++++++
 1 files changed

// File: rtl/kernel_weight_sram.sv
// Single-port kernel/weight memory responder with a configurable read pipeline.
// It tracks which words have been written and keeps saturating access counters.
module kernel_weight_sram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSB,
  input  logic              WEB,
  input  logic              OEB,
  input  logic [ADDR_W-1:0] ADD,
  input  logic [DATA_W-1:0] DATA_I,
  output logic [DATA_W-1:0] DATA_O,
  output logic              rd_valid,
  output logic              uninit_err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("kernel_weight_sram: RD_LAT must be in 1..3");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  init_bits_reg;
  logic              wr_fire;
  logic              rd_fire;

  assign wr_fire = !rst && !CSB && !WEB;
  assign rd_fire = !rst && !CSB &&  WEB;

  // Contents survive reset; only the written-flags are cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[ADD] <= DATA_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_bits_reg <= '0;
    end else if (wr_fire) begin
      init_bits_reg[ADD] <= 1'b1;
    end
  end

  // Stage inputs: stage 0 samples the array, later stages take the previous stage.
  logic [DATA_W-1:0] stg_data [RD_LAT];
  logic              stg_vld  [RD_LAT];
  logic              stg_init [RD_LAT];

  logic [DATA_W-1:0] pipe_data_reg [RD_LAT];
  logic              pipe_vld_reg  [RD_LAT];
  logic              pipe_init_reg [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stg_vld[gi]  = rd_fire;
        assign stg_init[gi] = init_bits_reg[ADD];
        assign stg_data[gi] = init_bits_reg[ADD] ? mem[ADD] : '0;
      end else begin : g_tail
        assign stg_vld[gi]  = pipe_vld_reg[gi-1];
        assign stg_init[gi] = pipe_init_reg[gi-1];
        assign stg_data[gi] = pipe_data_reg[gi-1];
      end
    end
  endgenerate

  // Data/init only load with a valid result so the last stage holds its value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (rst) begin
        pipe_vld_reg[i]  <= 1'b0;
        pipe_init_reg[i] <= 1'b0;
        pipe_data_reg[i] <= '0;
      end else begin
        pipe_vld_reg[i] <= stg_vld[i];
        if (stg_vld[i]) begin
          pipe_init_reg[i] <= stg_init[i];
          pipe_data_reg[i] <= stg_data[i];
        end
      end
    end
  end

  logic sticky_err_reg;
  logic last_uninit;

  assign last_uninit = pipe_vld_reg[RD_LAT-1] && !pipe_init_reg[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_err_reg <= 1'b0;
    end else if (last_uninit) begin
      sticky_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire && wr_cnt != '1) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rd_fire && rd_cnt != '1) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  assign rd_valid   = pipe_vld_reg[RD_LAT-1];
  assign uninit_err = sticky_err_reg || last_uninit;
  assign DATA_O     = OEB ? '0 : pipe_data_reg[RD_LAT-1];

endmodule
